// File: rtl/nes_tetris_pkg.sv
// -----------------------------------------------------------------------------
// nes_tetris_pkg
//   Shared definitions for the NES-Tetris board glue logic.
//   - deb_state_e           : per-key debounce FSM states
//   - DEBOUNCE_CYCLES_50MHZ : default hold time (10 ms at 50 MHz)
//   - KEY_WIDTH             : number of board push-buttons routed to the KEY PIO
// -----------------------------------------------------------------------------
package nes_tetris_pkg;

  // Debounce FSM: two settled states (UP/DOWN) and two qualifying states
  // that count consecutive samples of the opposite level.
  typedef enum logic [1:0] {
    UP     = 2'd0,
    CHK_DN = 2'd1,
    DOWN   = 2'd2,
    CHK_UP = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
  localparam int KEY_WIDTH             = 2;

endpackage : nes_tetris_pkg

// File: rtl/nes_tetris_key_debounce_bit.sv
// -----------------------------------------------------------------------------
// nes_tetris_key_debounce_bit
//   One key channel: synchroniser chain, hold-time debounce FSM and counter.
//   Ports:
//     clk           in  system clock
//     reset         in  asynchronous active-high reset
//     key_raw_n     in  raw button pin, active-low, asynchronous to clk
//     key_out_n     out debounced level, active-low (1 = released), registered
//     press_pulse   out one-cycle strobe when key_out_n goes 1->0
//     release_pulse out one-cycle strobe when key_out_n goes 0->1
// -----------------------------------------------------------------------------
module nes_tetris_key_debounce_bit
  import nes_tetris_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_n,
  output logic key_out_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Last count value: the sample that lands here while still differing is
  // the DEBOUNCE_CYCLES-th consecutive one, so the change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  deb_state_e             state_r;
  logic [CNT_W-1:0]       cnt_r;

  // Plain shift-register synchroniser; resets to "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_raw_n};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Debounce FSM with counter and registered level/strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= UP;
      cnt_r         <= CNT_ZERO;
      key_out_n     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless re-asserted below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state_r)
        UP: begin
          key_out_n <= 1'b1;
          if (!sync_s) begin
            state_r <= CHK_DN;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        CHK_DN: begin
          if (sync_s) begin
            // Bounced back before the hold time elapsed.
            state_r <= UP;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= DOWN;
            cnt_r       <= CNT_ZERO;
            key_out_n   <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DOWN: begin
          key_out_n <= 1'b0;
          if (sync_s) begin
            state_r <= CHK_UP;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        CHK_UP: begin
          if (!sync_s) begin
            state_r <= DOWN;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r       <= UP;
            cnt_r         <= CNT_ZERO;
            key_out_n     <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= UP;
          cnt_r     <= CNT_ZERO;
          key_out_n <= 1'b1;
        end
      endcase
    end
  end

endmodule : nes_tetris_key_debounce_bit

// File: rtl/nes_tetris_key_debounce.sv
// -----------------------------------------------------------------------------
// nes_tetris_key_debounce
//   Conditions the bouncing active-low board push-buttons before the KEY PIO.
//   Each channel is fully independent; this level is wiring only.
//   Ports:
//     clk           in  [1]     system clock
//     reset         in  [1]     asynchronous active-high reset
//     key_raw_n     in  [WIDTH] raw button pins, active-low
//     key_out_n     out [WIDTH] debounced level, active-low (to PIO in_port)
//     press_pulse   out [WIDTH] one-cycle strobe on key_out_n 1->0
//     release_pulse out [WIDTH] one-cycle strobe on key_out_n 0->1
// -----------------------------------------------------------------------------
module nes_tetris_key_debounce
  import nes_tetris_pkg::*;
#(
  parameter int WIDTH           = KEY_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw_n,
  output logic [WIDTH-1:0] key_out_n,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_key
    nes_tetris_key_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk           (clk),
      .reset         (reset),
      .key_raw_n     (key_raw_n[g]),
      .key_out_n     (key_out_n[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g])
    );
  end

endmodule : nes_tetris_key_debounce

// File: tb/tb_nes_tetris_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_nes_tetris_key_debounce
//   Directed bench for nes_tetris_key_debounce with DEBOUNCE_CYCLES=8 and
//   SYNC_STAGES=2, so an accepted change appears 10 edges after the first
//   edge that samples the new raw value. Inputs change 1 ns after a rising
//   edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nes_tetris_key_debounce;

  localparam int W = 2;

  logic         clk;
  logic         reset;
  logic [W-1:0] key_raw_n;
  logic [W-1:0] key_out_n;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;

  int n_tests;
  int n_fail;

  nes_tetris_key_debounce #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_raw_n     (key_raw_n),
    .key_out_n     (key_out_n),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] out_e,
                            input logic [1:0] prs_e, input logic [1:0] rel_e);
    check_val({tag, "_out"}, 32'(key_out_n), 32'(out_e));
    check_val({tag, "_prs"}, 32'(press_pulse), 32'(prs_e));
    check_val({tag, "_rel"}, 32'(release_pulse), 32'(rel_e));
  endtask

  // Called right after driving a new raw value: no change through edge 9,
  // change plus strobe exactly at edge 10, strobe gone at edge 11.
  task automatic expect_change(input string tag, input logic [1:0] out_before,
                               input logic [1:0] out_after,
                               input logic [1:0] prs_e, input logic [1:0] rel_e);
    tick(9);
    check_outs({tag, "_e9"}, out_before, 2'b00, 2'b00);
    tick(1);
    check_outs({tag, "_e10"}, out_after, prs_e, rel_e);
    tick(1);
    check_outs({tag, "_e11"}, out_after, 2'b00, 2'b00);
  endtask

  int glitch_len [4] = '{2, 5, 7, 3};

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_raw_n = 2'b00;

    // 1. Reset with keys held, then release reset: both re-debounced.
    tick(3);
    check_outs("t1_rst", 2'b11, 2'b00, 2'b00);
    reset = 1'b0;
    expect_change("t1_press", 2'b11, 2'b00, 2'b11, 2'b00);
    key_raw_n = 2'b11;
    expect_change("t1_rel", 2'b00, 2'b11, 2'b00, 2'b11);

    // 2. Clean press/release on key 0.
    key_raw_n = 2'b10;
    expect_change("t2_press", 2'b11, 2'b10, 2'b01, 2'b00);
    tick(8);
    key_raw_n = 2'b11;
    expect_change("t2_rel", 2'b10, 2'b11, 2'b00, 2'b01);

    // 3. Key 1 bouncing with 3-cycle runs: nothing reaches the outputs.
    for (int i = 0; i < 40; i++) begin
      key_raw_n = {(((i / 3) % 2) != 0), 1'b1};
      tick(1);
      check_val("t3_out", 32'(key_out_n), 32'(2'b11));
      check_val("t3_pulses", 32'({press_pulse, release_pulse}), 32'(4'b0000));
    end
    key_raw_n = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_val("t3_tail", 32'({key_out_n, press_pulse, release_pulse}), 32'(6'b110000));
    end

    // 4. Glitches shorter than the hold time, then a steady press on key 1.
    for (int g = 0; g < 4; g++) begin
      key_raw_n = 2'b01;
      for (int i = 0; i < glitch_len[g]; i++) begin
        tick(1);
        check_val("t4_glitch", 32'({key_out_n, press_pulse, release_pulse}), 32'(6'b110000));
      end
      key_raw_n = 2'b11;
      for (int i = 0; i < 2; i++) begin
        tick(1);
        check_val("t4_gap", 32'({key_out_n, press_pulse, release_pulse}), 32'(6'b110000));
      end
    end
    key_raw_n = 2'b01;
    expect_change("t4_press", 2'b11, 2'b01, 2'b10, 2'b00);
    key_raw_n = 2'b11;
    expect_change("t4_rel", 2'b01, 2'b11, 2'b00, 2'b10);

    // 5. Simultaneous press; releases 5 cycles apart.
    key_raw_n = 2'b00;
    expect_change("t5_press", 2'b11, 2'b00, 2'b11, 2'b00);
    key_raw_n = 2'b01;
    tick(5);
    key_raw_n = 2'b11;
    tick(4);
    check_outs("t5_r0_e9", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_outs("t5_r0_e10", 2'b01, 2'b00, 2'b01);
    tick(4);
    check_outs("t5_r1_e14", 2'b01, 2'b00, 2'b00);
    tick(1);
    check_outs("t5_r1_e15", 2'b11, 2'b00, 2'b10);
    tick(1);
    check_outs("t5_r1_e16", 2'b11, 2'b00, 2'b00);

    // 6a. Reset while key 0 is mid-qualification (cnt=5 after edge 7).
    key_raw_n = 2'b10;
    tick(7);
    reset = 1'b1;
    #1;
    check_outs("t6a_rst", 2'b11, 2'b00, 2'b00);
    tick(2);
    check_outs("t6a_hold", 2'b11, 2'b00, 2'b00);
    reset = 1'b0;
    expect_change("t6a_press", 2'b11, 2'b10, 2'b01, 2'b00);

    // 6b. Reset while key 0 is DOWN: released immediately, then re-pressed.
    reset = 1'b1;
    #1;
    check_outs("t6b_rst", 2'b11, 2'b00, 2'b00);
    tick(1);
    reset = 1'b0;
    expect_change("t6b_press", 2'b11, 2'b10, 2'b01, 2'b00);
    key_raw_n = 2'b11;
    expect_change("t6b_rel", 2'b10, 2'b11, 2'b00, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_nes_tetris_key_debounce
